traffic_phase_scheduler: RTL

Actuated phase scheduler for a two-road intersection. It drives the main_road/side_road lamp triplets with the same encoding as traffic_light_controller. Main road rests in green. The side road is served only on demand: a vehicle sensor or a pedestrian button. An emergency preempt holds or returns green to the main road. Sits between the intersection sensor/button inputs and the lamp drivers.

---
 rtl/traffic_phase_scheduler.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/traffic_phase_scheduler.sv
// -----------------------------------------------------------------------------
// traffic_phase_scheduler
//
// Actuated phase scheduler for a two-road intersection. The main road rests in
// green; the side road is served only when a vehicle or pedestrian demand has
// been latched. An emergency preempt holds green on the main road or cuts a
// running side green short (yellow and all-red always complete).
//
// Ports:
//   clk           system clock, rising edge
//   reset         asynchronous, active-high reset
//   side_req      side-road vehicle sensor, sampled each cycle
//   ped_req       pedestrian button, sampled each cycle (pulse or level)
//   emerg         emergency preempt, level
//   main_road     main-road lamps {red,yellow,green}, one-hot
//   side_road     side-road lamps {red,yellow,green}, one-hot
//   walk          pedestrian walk lamp
//   side_pending  latched vehicle demand
//   ped_pending   latched pedestrian demand
//   phase         current state code
// -----------------------------------------------------------------------------
module traffic_phase_scheduler #(
  parameter int GREEN_MIN    = 8,
  parameter int YELLOW_T     = 3,
  parameter int ALLRED_T     = 2,
  parameter int SIDE_GREEN_T = 6,
  parameter int PED_WALK_T   = 4,
  parameter int CNT_W        = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       side_req,
  input  logic       ped_req,
  input  logic       emerg,
  output logic [2:0] main_road,
  output logic [2:0] side_road,
  output logic       walk,
  output logic       side_pending,
  output logic       ped_pending,
  output logic [2:0] phase
);

  typedef enum logic [2:0] {
    MAIN_GREEN  = 3'd0,
    MAIN_YELLOW = 3'd1,
    ALL_RED1    = 3'd2,
    SIDE_GREEN  = 3'd3,
    SIDE_YELLOW = 3'd4,
    ALL_RED2    = 3'd5
  } state_t;

  localparam logic [2:0] LAMP_RED = 3'b100;
  localparam logic [2:0] LAMP_YEL = 3'b010;
  localparam logic [2:0] LAMP_GRN = 3'b001;

  // Last timer value of each state: a state of duration T exits when timer==T-1.
  localparam logic [CNT_W-1:0] GREEN_LAST  = CNT_W'(GREEN_MIN - 1);
  localparam logic [CNT_W-1:0] YELLOW_LAST = CNT_W'(YELLOW_T - 1);
  localparam logic [CNT_W-1:0] ALLRED_LAST = CNT_W'(ALLRED_T - 1);
  localparam logic [CNT_W-1:0] SIDE_LAST   = CNT_W'(SIDE_GREEN_T - 1);
  localparam logic [CNT_W-1:0] WALK_LAST   = CNT_W'(PED_WALK_T - 1);

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] timer;
  logic             state_change;
  logic             side_green_entry;
  logic             sample_req;

  // Lamp pair {main, side} for a state; unused codes show all-red.
  function automatic logic [5:0] lamps_for(input state_t s);
    case (s)
      MAIN_GREEN:  lamps_for = {LAMP_GRN, LAMP_RED};
      MAIN_YELLOW: lamps_for = {LAMP_YEL, LAMP_RED};
      SIDE_GREEN:  lamps_for = {LAMP_RED, LAMP_GRN};
      SIDE_YELLOW: lamps_for = {LAMP_RED, LAMP_YEL};
      default:     lamps_for = {LAMP_RED, LAMP_RED};
    endcase
  endfunction

  always_comb begin
    // NOTE: default assignment first so every path drives state_nxt and no latch is inferred.
    state_nxt = MAIN_GREEN;
    case (state)
      MAIN_GREEN:
        state_nxt = (timer == GREEN_LAST && (side_pending || ped_pending) && !emerg)
                    ? MAIN_YELLOW : MAIN_GREEN;
      MAIN_YELLOW:
        state_nxt = (timer == YELLOW_LAST) ? ALL_RED1 : MAIN_YELLOW;
      ALL_RED1:
        // Preempt arriving during clearance returns to main green; demands stay latched.
        state_nxt = (timer != ALLRED_LAST) ? ALL_RED1 :
                    (emerg ? MAIN_GREEN : SIDE_GREEN);
      SIDE_GREEN:
        state_nxt = (emerg || timer == SIDE_LAST) ? SIDE_YELLOW : SIDE_GREEN;
      SIDE_YELLOW:
        state_nxt = (timer == YELLOW_LAST) ? ALL_RED2 : SIDE_YELLOW;
      ALL_RED2:
        state_nxt = (timer == ALLRED_LAST) ? MAIN_GREEN : ALL_RED2;
      default:
        state_nxt = MAIN_GREEN;
    endcase
  end

  assign state_change     = (state_nxt != state);
  assign side_green_entry = (state_nxt == SIDE_GREEN) && (state != SIDE_GREEN);
  // Requests arriving while the side road is already being served are dropped.
  assign sample_req       = (state != SIDE_GREEN);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= MAIN_GREEN;
      timer        <= '0;
      main_road    <= LAMP_GRN;
      side_road    <= LAMP_RED;
      walk         <= 1'b0;
      side_pending <= 1'b0;
      ped_pending  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state                  <= state_nxt;
      {main_road, side_road} <= lamps_for(state_nxt);

      // Main green saturates at its minimum so it can wait indefinitely for demand.
      if (state_change)
        timer <= '0;
      else if (!(state == MAIN_GREEN && timer == GREEN_LAST))
        timer <= timer + CNT_W'(1);

      // Clearing on side-green entry wins over a request in the same cycle.
      side_pending <= !side_green_entry && (side_pending || (sample_req && side_req));
      ped_pending  <= !side_green_entry && (ped_pending  || (sample_req && ped_req));

      // Walk is captured from the pedestrian demand at side-green entry and
      // lasts the first PED_WALK_T cycles; any exit from side green drops it.
      if (side_green_entry)
        walk <= ped_pending;
      else if (state_nxt != SIDE_GREEN || timer == WALK_LAST)
        walk <= 1'b0;
    end
  end

  assign phase = state;

endmodule
